// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, access op encoding, cause codes and register layouts.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_READ = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [4:0] EXC_INSTR_MISALIGNED = 5'd0;
  localparam logic [4:0] EXC_ILLEGAL_INSTR    = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT       = 5'd3;
  localparam logic [4:0] EXC_LOAD_FAULT       = 5'd5;
  localparam logic [4:0] EXC_ECALL_M          = 5'd11;
  localparam int         IRQ_CAUSE_BASE       = 16;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef struct packed {
    logic [18:0] rsv_hi;
    logic [1:0]  mpp;
    logic [2:0]  rsv_mid;
    logic        mpie;
    logic [2:0]  rsv_lo;
    logic        mie;
    logic [2:0]  rsv_low;
  } mstatus_t;

  typedef struct packed {
    logic [29:0] base;
    logic [1:0]  mode;
  } mtvec_t;

  typedef struct packed {
    logic        irq;
    logic [30:0] code;
  } mcause_t;

  function automatic logic [31:0] csr_update(csr_op_e op, logic [31:0] old_val,
                                             logic [31:0] wdata);
    case (op)
      CSR_OP_RW: csr_update = wdata;
      CSR_OP_RS: csr_update = old_val | wdata;
      CSR_OP_RC: csr_update = old_val & ~wdata;
      default:   csr_update = old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_unit_irq_sync.sv
// Multi-flop synchroniser for asynchronous level inputs (irq_sync).
// Depth must be at least 2; output lags the input by STAGES edges.
module irq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap/mret sequencer with registered redirect to fetch.
// Optional CSR_COUNTERS_EN adds 64-bit mcycle/minstret; otherwise those addresses fault.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int          NUM_IRQ         = 4,
  parameter logic [31:0] RESET_MTVEC     = 32'h0000_0000,
  parameter int          IRQ_SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_valid,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        exc_pc,
  input  logic [31:0]        exc_tval,
  input  logic               mret_valid,
  input  logic               boundary,
  input  logic [31:0]        boundary_pc,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               irq_pending
);

  typedef enum logic {RUN, REDIRECT} state_e;

  state_e             state_q, state_d;
  logic               st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  mtvec_t             mtvec_q, mtvec_d;
  logic [NUM_IRQ-1:0] mie_en_q, mie_en_d;
  logic [31:0]        mscratch_q, mscratch_d, mepc_q, mepc_d, mtval_q, mtval_d;
  mcause_t            mcause_q, mcause_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic [NUM_IRQ-1:0] irq_sync_w;
`ifdef CSR_COUNTERS_EN
  logic [63:0]        mcycle_q, mcycle_d, minstret_q, minstret_d;
`endif

  logic [31:0] mip_w, mie_w, rdata_w, wval;
  mstatus_t    mstatus_w;
  logic        addr_ok, irq_hit, take_irq;
  logic [4:0]  irq_idx;
  mcause_t     irq_cause;
  logic [31:0] trap_base;

  irq_sync #(.WIDTH(NUM_IRQ), .STAGES(IRQ_SYNC_STAGES)) u_irq_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_i),
    .q     (irq_sync_w)
  );

  // Read mux; addr_ok drops for any address this hart does not implement.
  always_comb begin
    mip_w = '0;
    mip_w[IRQ_CAUSE_BASE +: NUM_IRQ] = irq_sync_w;
    mie_w = '0;
    mie_w[IRQ_CAUSE_BASE +: NUM_IRQ] = mie_en_q;
    mstatus_w      = '0;
    mstatus_w.mpp  = 2'b11;
    mstatus_w.mpie = st_mpie_q;
    mstatus_w.mie  = st_mie_q;
    rdata_w = '0;
    addr_ok = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   rdata_w = mstatus_w;
      CSR_MIE:       rdata_w = mie_w;
      CSR_MTVEC:     rdata_w = mtvec_q;
      CSR_MSCRATCH:  rdata_w = mscratch_q;
      CSR_MEPC:      rdata_w = mepc_q;
      CSR_MCAUSE:    rdata_w = mcause_q;
      CSR_MTVAL:     rdata_w = mtval_q;
      CSR_MIP:       rdata_w = mip_w;
      CSR_MHARTID:   rdata_w = '0;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    rdata_w = mcycle_q[31:0];
      CSR_MCYCLEH:   rdata_w = mcycle_q[63:32];
      CSR_MINSTRET:  rdata_w = minstret_q[31:0];
      CSR_MINSTRETH: rdata_w = minstret_q[63:32];
`endif
      default:       addr_ok = 1'b0;
    endcase
  end

  assign csr_rdata   = rdata_w;
  assign csr_illegal = csr_valid &&
                       (!addr_ok || (csr_addr[11:10] == 2'b11 && csr_op != CSR_OP_READ));

  // Descending scan so the lowest pending line wins.
  always_comb begin
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_sync_w[i] && mie_en_q[i]) begin
        irq_hit = 1'b1;
        irq_idx = 5'(i);
      end
    end
    irq_cause.irq  = 1'b1;
    irq_cause.code = 31'(IRQ_CAUSE_BASE) + 31'(irq_idx);
  end

  assign irq_pending = st_mie_q && irq_hit;
  assign take_irq    = boundary && !exc_valid && irq_pending;
  assign trap_base   = {mtvec_q.base, 2'b00};
  assign wval        = csr_update(csr_op_e'(csr_op), rdata_w, csr_wdata);

  // Next-state: exception > interrupt > mret > CSR write, all only while in RUN.
  always_comb begin
    state_d       = state_q;
    st_mie_d      = st_mie_q;
    st_mpie_d     = st_mpie_q;
    mtvec_d       = mtvec_q;
    mie_en_d      = mie_en_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    redirect_pc_d = redirect_pc_q;
`ifdef CSR_COUNTERS_EN
    mcycle_d      = mcycle_q + 64'd1;
    minstret_d    = minstret_q + 64'((state_q == RUN) && boundary);
`endif
    case (state_q)
      RUN: begin
        if (exc_valid) begin
          mepc_d        = exc_pc & ~32'h3;
          mcause_d      = {1'b0, 26'b0, exc_code};
          mtval_d       = exc_tval;
          st_mpie_d     = st_mie_q;
          st_mie_d      = 1'b0;
          redirect_pc_d = trap_base;
          state_d       = REDIRECT;
        end else if (take_irq) begin
          mepc_d        = boundary_pc & ~32'h3;
          mcause_d      = irq_cause;
          mtval_d       = '0;
          st_mpie_d     = st_mie_q;
          st_mie_d      = 1'b0;
          redirect_pc_d = (mtvec_q.mode == MTVEC_VECTORED) ?
                          trap_base + {irq_cause.code[29:0], 2'b00} : trap_base;
          state_d       = REDIRECT;
        end else if (mret_valid) begin
          st_mie_d      = st_mpie_q;
          st_mpie_d     = 1'b1;
          redirect_pc_d = mepc_q;
          state_d       = REDIRECT;
        end else if (csr_valid && !csr_illegal && csr_op != CSR_OP_READ) begin
          case (csr_addr)
            CSR_MSTATUS: begin
              st_mie_d  = wval[3];
              st_mpie_d = wval[7];
            end
            CSR_MIE:       mie_en_d = wval[IRQ_CAUSE_BASE +: NUM_IRQ];
            CSR_MTVEC: begin
              mtvec_d.base = wval[31:2];
              if (!wval[1]) mtvec_d.mode = wval[1:0];
            end
            CSR_MSCRATCH:  mscratch_d = wval;
            CSR_MEPC:      mepc_d     = wval & ~32'h3;
            CSR_MCAUSE:    mcause_d   = wval;
            CSR_MTVAL:     mtval_d    = wval;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wval};
            CSR_MCYCLEH:   mcycle_d   = {wval, mcycle_q[31:0]};
            CSR_MINSTRET:  minstret_d = {minstret_q[63:32], wval};
            CSR_MINSTRETH: minstret_d = {wval, minstret_q[31:0]};
`endif
            default: ;
          endcase
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      st_mie_q      <= 1'b0;
      st_mpie_q     <= 1'b0;
      mtvec_q       <= RESET_MTVEC;
      mie_en_q      <= '0;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      redirect_pc_q <= '0;
`ifdef CSR_COUNTERS_EN
      mcycle_q      <= '0;
      minstret_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      st_mie_q      <= st_mie_d;
      st_mpie_q     <= st_mpie_d;
      mtvec_q       <= mtvec_d;
      mie_en_q      <= mie_en_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      redirect_pc_q <= redirect_pc_d;
`ifdef CSR_COUNTERS_EN
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
`endif
    end
  end

  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: table of CSR accesses plus hand-written
// trap, interrupt, mret and reset-during-redirect sequences.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic        boundary;
  logic [31:0] boundary_pc;
  logic [3:0]  irq_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        irq_pending;

  csr_trap_unit #(.NUM_IRQ(4), .RESET_MTVEC(32'h0000_0000), .IRQ_SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .csr_valid      (csr_valid),
    .csr_op         (csr_op),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_illegal    (csr_illegal),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .mret_valid     (mret_valid),
    .boundary       (boundary),
    .boundary_pc    (boundary_pc),
    .irq_i          (irq_i),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .irq_pending    (irq_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_illegal;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        illegal;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb_q[$];
  logic [31:0] redir_q[$];
  int          checks = 0;
  int          fails  = 0;

  task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clearRequests();
    csr_valid  = 1'b0;
    csr_op     = 2'b00;
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
    boundary   = 1'b0;
  endtask

  // Drive one CSR access at the falling edge and queue its expected result.
  task automatic applyStimulus(vec_t v, string name);
    exp_t e;
    @(negedge clk);
    clearRequests();
    csr_valid = 1'b1;
    csr_op    = v.op;
    csr_addr  = v.addr;
    csr_wdata = v.wdata;
    e.name    = name;
    e.rdata   = v.exp_rdata;
    e.illegal = v.exp_illegal;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    #1;
    e = sb_q.pop_front();
    checkValue({e.name, " rdata"}, csr_rdata, e.rdata);
    checkValue({e.name, " illegal"}, 32'(csr_illegal), 32'(e.illegal));
  endtask

  task automatic access(logic [1:0] op, logic [11:0] addr, logic [31:0] wdata,
                        logic [31:0] exp_rdata, logic exp_ill, string name);
    vec_t v;
    v = '{op, addr, wdata, exp_rdata, exp_ill};
    applyStimulus(v, name);
    checkOutput();
  endtask

  task automatic readCheck(logic [11:0] addr, logic [31:0] exp, string name);
    access(2'b00, addr, 32'h0, exp, 1'b0, name);
  endtask

  task automatic driveEvent(logic exc, logic [4:0] code, logic [31:0] pc, logic [31:0] tval,
                            logic mret, logic bnd, logic [31:0] bpc, logic [31:0] exp_target);
    @(negedge clk);
    clearRequests();
    exc_valid   = exc;
    exc_code    = code;
    exc_pc      = pc;
    exc_tval    = tval;
    mret_valid  = mret;
    boundary    = bnd;
    boundary_pc = bpc;
    redir_q.push_back(exp_target);
  endtask

  // Bounded wait for the redirect pulse; optionally confirm it lasts one cycle.
  task automatic waitRedirect(string name, bit pulse_check);
    bit          seen = 1'b0;
    logic [31:0] exp;
    @(negedge clk);
    clearRequests();
    for (int c = 0; c < 8 && !seen; c++) begin
      if (redirect_valid) begin
        seen = 1'b1;
        exp  = redir_q.pop_front();
        checkValue({name, " redirect_pc"}, redirect_pc, exp);
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s redirect timeout: got no pulse, expected one within 8 cycles", name);
      if (redir_q.size() > 0) void'(redir_q.pop_front());
    end
    if (pulse_check) begin
      @(negedge clk);
      checkValue({name, " pulse end"}, 32'(redirect_valid), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    exc_code    = '0;
    exc_pc      = '0;
    exc_tval    = '0;
    boundary_pc = '0;
    irq_i       = '0;
    clearRequests();

    vecs.push_back('{2'b00, 12'h300, 32'h0,          32'h0000_1800, 1'b0});
    vecs.push_back('{2'b00, 12'h305, 32'h0,          32'h0000_0000, 1'b0});
    vecs.push_back('{2'b00, 12'h7C0, 32'h0,          32'h0000_0000, 1'b1});
    vecs.push_back('{2'b01, 12'h305, 32'h8000_0002,  32'h0000_0000, 1'b0});
    vecs.push_back('{2'b00, 12'h305, 32'h0,          32'h8000_0000, 1'b0});
    vecs.push_back('{2'b01, 12'h305, 32'h0000_2001,  32'h8000_0000, 1'b0});
    vecs.push_back('{2'b01, 12'h305, 32'h0000_3003,  32'h0000_2001, 1'b0});
    vecs.push_back('{2'b00, 12'h305, 32'h0,          32'h0000_3001, 1'b0});
    vecs.push_back('{2'b10, 12'h340, 32'h0000_00F0,  32'h0000_0000, 1'b0});
    vecs.push_back('{2'b11, 12'h340, 32'h0000_0030,  32'h0000_00F0, 1'b0});
    vecs.push_back('{2'b00, 12'h340, 32'h0,          32'h0000_00C0, 1'b0});
    vecs.push_back('{2'b00, 12'hF14, 32'h0,          32'h0000_0000, 1'b0});
    vecs.push_back('{2'b01, 12'hF14, 32'h0000_0001,  32'h0000_0000, 1'b1});
    vecs.push_back('{2'b01, 12'h300, 32'hFFFF_FFFF,  32'h0000_1800, 1'b0});
    vecs.push_back('{2'b00, 12'h300, 32'h0,          32'h0000_1888, 1'b0});
    vecs.push_back('{2'b11, 12'h300, 32'h0000_0080,  32'h0000_1888, 1'b0});
    vecs.push_back('{2'b00, 12'h300, 32'h0,          32'h0000_1808, 1'b0});
    vecs.push_back('{2'b01, 12'h341, 32'h0000_0103,  32'h0000_0000, 1'b0});
    vecs.push_back('{2'b00, 12'h341, 32'h0,          32'h0000_0100, 1'b0});
    vecs.push_back('{2'b01, 12'h344, 32'hFFFF_FFFF,  32'h0000_0000, 1'b0});
    vecs.push_back('{2'b00, 12'h344, 32'h0,          32'h0000_0000, 1'b0});
    vecs.push_back('{2'b01, 12'h304, 32'hFFFF_FFFF,  32'h0000_0000, 1'b0});
    vecs.push_back('{2'b00, 12'h304, 32'h0,          32'h000F_0000, 1'b0});
    vecs.push_back('{2'b01, 12'h304, 32'h0,          32'h000F_0000, 1'b0});
    vecs.push_back('{2'b01, 12'h342, 32'h8000_0003,  32'h0000_0000, 1'b0});
    vecs.push_back('{2'b00, 12'h342, 32'h0,          32'h8000_0003, 1'b0});
`ifndef CSR_COUNTERS_EN
    vecs.push_back('{2'b00, 12'hB00, 32'h0,          32'h0000_0000, 1'b1});
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    checkValue("reset redirect_valid", 32'(redirect_valid), 32'h0);
    checkValue("reset redirect_pc", redirect_pc, 32'h0);
    checkValue("reset irq_pending", 32'(irq_pending), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checkOutput();
    end

    // Synchronous exception.
    access(2'b01, 12'h305, 32'h0000_4000, 32'h0000_3001, 1'b0, "mtvec set");
    driveEvent(1'b1, 5'd2, 32'h100, 32'hDEAD, 1'b0, 1'b0, 32'h0, 32'h0000_4000);
    waitRedirect("exc", 1'b1);
    readCheck(12'h342, 32'h0000_0002, "exc mcause");
    readCheck(12'h341, 32'h0000_0100, "exc mepc");
    readCheck(12'h343, 32'h0000_DEAD, "exc mtval");
    readCheck(12'h300, 32'h0000_1880, "exc mstatus");

    // mret restores MIE from MPIE.
    driveEvent(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0000_0100);
    waitRedirect("mret1", 1'b1);
    readCheck(12'h300, 32'h0000_1888, "mret1 mstatus");

    // Vectored interrupt on line 1 through the synchroniser.
    access(2'b01, 12'h305, 32'h0000_2001, 32'h0000_4000, 1'b0, "mtvec vec");
    access(2'b01, 12'h304, 32'h0002_0000, 32'h0000_0000, 1'b0, "mie set");
    @(negedge clk);
    clearRequests();
    irq_i = 4'b0010;
    readCheck(12'h344, 32'h0000_0000, "mip after 1 edge");
    readCheck(12'h344, 32'h0002_0000, "mip after 2 edges");
    checkValue("irq_pending raised", 32'(irq_pending), 32'h1);
    driveEvent(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h44, 32'h0000_2044);
    waitRedirect("irq", 1'b1);
    readCheck(12'h342, 32'h8000_0011, "irq mcause");
    readCheck(12'h341, 32'h0000_0044, "irq mepc");
    readCheck(12'h343, 32'h0000_0000, "irq mtval");
    readCheck(12'h300, 32'h0000_1880, "irq mstatus");

    driveEvent(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0000_0044);
    waitRedirect("mret2", 1'b1);
    #1;
    checkValue("irq_pending after mret", 32'(irq_pending), 32'h1);

    // Exception beats pending IRQ, mret and CSR write in one cycle.
    driveEvent(1'b1, 5'd5, 32'h200, 32'h11, 1'b1, 1'b1, 32'h300, 32'h0000_2000);
    csr_valid = 1'b1;
    csr_op    = 2'b01;
    csr_addr  = 12'h340;
    csr_wdata = 32'h5555;
    #1;
    checkValue("prio rdata", csr_rdata, 32'h0000_00C0);
    waitRedirect("prio", 1'b1);
    readCheck(12'h340, 32'h0000_00C0, "prio mscratch");
    readCheck(12'h342, 32'h0000_0005, "prio mcause");
    readCheck(12'h341, 32'h0000_0200, "prio mepc");
    readCheck(12'h343, 32'h0000_0011, "prio mtval");
    readCheck(12'h300, 32'h0000_1880, "prio mstatus");

    // Reset asserted while the mret redirect is being presented.
    @(negedge clk);
    clearRequests();
    irq_i = 4'b0000;
    driveEvent(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0000_0200);
    waitRedirect("mret3", 1'b0);
    rst_n = 1'b0;
    #1;
    checkValue("reset mid-redirect valid", 32'(redirect_valid), 32'h0);
    checkValue("reset mid-redirect pc", redirect_pc, 32'h0);
    csr_valid = 1'b1;
    csr_op    = 2'b00;
    csr_addr  = 12'h300;
    #1;
    checkValue("reset mstatus", csr_rdata, 32'h0000_1800);
    csr_addr = 12'h305;
    #1;
    checkValue("reset mtvec", csr_rdata, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    clearRequests();
    repeat (2) @(negedge clk);
    checkValue("post-reset redirect_valid", 32'(redirect_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR file and trap sequencer for the rv32 core.
- Holds mstatus/mie/mip/mtvec/mscratch/mepc/mcause/mtval and executes CSRRW/CSRRS/CSRRC accesses from execute.
- Sequences exception/interrupt entry and mret, and drives a registered redirect PC to fetch.
- Generalises the existing mstatus_t/mtvec_t/mcause_t layouts: parametrised local-interrupt count, vectored mtvec mode, synchronised IRQ inputs.

Parameters:
NUM_IRQ, 4, local interrupt lines (1..16); line i maps to cause 16+i
RESET_MTVEC, 32'h0000_0000, mtvec reset value (bits[1:0] are the mode)
IRQ_SYNC_STAGES, 2, synchroniser depth for irq_i (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
csr_valid  in  1  CSR access request this cycle
csr_op  in  2  01 RW, 10 RS, 11 RC, 00 read-only access
csr_addr  in  12  CSR address
csr_wdata  in  32  rs1 value or zimm
csr_rdata  out  32  combinational read data (old value)
csr_illegal  out  1  combinational; access faults
exc_valid  in  1  synchronous exception from pipeline
exc_code  in  5  exception cause code
exc_pc  in  32  faulting instruction PC
exc_tval  in  32  trap value
mret_valid  in  1  mret retiring
boundary  in  1  instruction boundary; interrupt may be taken
boundary_pc  in  32  PC of next instruction at boundary
irq_i  in  NUM_IRQ  asynchronous level interrupts
redirect_valid  out  1  registered one-cycle pulse
redirect_pc  out  32  registered target
irq_pending  out  1  any enabled pending IRQ and mstatus.MIE

Behaviour:
- Reset (async, rst_n low):
  - mstatus = 0 except MPP = 2'b11.
  - mtvec = RESET_MTVEC.
  - mie, mscratch, mepc, mcause, mtval = 0.
  - Synchroniser flops cleared.
  - redirect_valid = 0, redirect_pc = 0.
- Implemented fields:
  - mstatus (0x300): MIE, MPIE only; MPP reads 11; all other bits read 0, writes ignored.
  - mie (0x304): bits [16+NUM_IRQ-1:16] writable.
  - mip (0x344): read-only; bits [16+i] = synchronised irq_i.
  - mtvec (0x305): WARL; a write with mode 2/3 keeps the previous mode and updates base.
  - mepc (0x341): bits [1:0] forced 0.
  - mscratch (0x340), mcause (0x342), mtval (0x343): full 32 bits.
  - mhartid (0xF14): reads 0.
- Access rules:
  - Write value: RW = wdata; RS = old|wdata; RC = old&~wdata. It takes effect at the next edge.
  - csr_illegal when csr_valid and: the address is unimplemented, or addr[11:10]==11 with op != 00. No state changes on an illegal access.
- Priority per cycle: exc_valid > interrupt > mret_valid > CSR write. The losing CSR write or mret is dropped; the pipeline is flushed by the redirect.
- Interrupt taken when: boundary=1, exc_valid=0, mstatus.MIE=1, and (mip & mie) != 0. Lowest index i wins; cause = {1'b1, 31'(16+i)}; mepc = boundary_pc; mtval = 0.
- Trap entry, at the edge:
  - mepc, mcause, mtval updated.
  - MPIE <= MIE; MIE <= 0.
  - Next cycle: redirect_valid=1 with redirect_pc = {base,2'b00}.
  - When the interrupt arrives with mode=1, redirect_pc = {base,2'b00} + 4*cause[30:0].
- mret, at the edge: MIE <= MPIE; MPIE <= 1. Next cycle: redirect_valid=1, redirect_pc = mepc.
- FSM states: RUN, REDIRECT.
  - RUN -> REDIRECT on trap or mret.
  - REDIRECT -> RUN unconditionally.
  - All request inputs are ignored in REDIRECT; the pipeline is flushing.
- IRQ latency: an irq_i change is visible in mip IRQ_SYNC_STAGES cycles later.
- Reset mid-REDIRECT returns to RUN with redirect_valid=0.

Optional Feature:
- CSR_COUNTERS_EN defined:
  - 64-bit mcycle (0xB00/0xB80) increments every cycle.
  - 64-bit minstret (0xB02/0xB82) increments on boundary.
  - Both are writable; on the edge of a software write, the written half loads and no increment applies. Carry propagates from low to high.
- Not defined: those addresses are unimplemented (csr_illegal).

Decomposition:
- Shared package (csr_pkg): CSR address localparams, exception/interrupt cause codes, csr_op encoding, plus existing mstatus_t, mtvec_t, mcause_t.
- One sub-module: irq_sync (parametrised depth/width multi-flop synchroniser, async active-low reset).

Test Plan:
- Reset, then read 0x300 and 0x305 -> 0x0000_1800 and RESET_MTVEC; read 0x7C0 -> csr_illegal=1.
- CSRRW mtvec 0x8000_0002 -> mtvec reads 0x8000_0000 (mode kept 0). CSRRS mscratch 0xF0 then CSRRC 0x30 -> 0xC0.
- mstatus.MIE=1; exc_valid with code 2, pc 0x100, tval 0xDEAD -> mcause=2, mepc=0x100, mtval=0xDEAD, MIE=0, MPIE=1; next cycle redirect_pc=mtvec base.
- mtvec=0x0000_2001, mie bit17 set, MIE=1; raise irq_i[1]. After 2 cycles a boundary at pc 0x44 -> mcause=0x8000_0011, redirect_pc=0x2044, mepc=0x44.
- exc_valid, CSR write to mscratch and pending IRQ in the same cycle -> exception taken, mscratch unchanged, mcause = exception code.
- mret after trap -> redirect_pc=mepc, MIE=1, MPIE=1; assert rst_n=0 during REDIRECT -> redirect_valid=0 immediately.
